// File: rtl/lmc_link_config_ctrl_if.sv
// Config request / LMC datapath bundle for lmc_link_config_ctrl.
// drain_timeout exists only when LMC_CTRL_DRAIN_TIMEOUT_EN is defined.
interface lmc_link_config_ctrl_if;
    logic        cfg_req;
    logic [2:0]  cfg_gen;
    logic [4:0]  cfg_lanes;
    logic        cfg_ack;
    logic        cfg_err;
    logic        busy;
    logic [15:0] descramblerDataValid;
    logic [2:0]  lmc_gen;
    logic [4:0]  lmc_lanes;
    logic        lmc_flush;
    logic        lmc_valid_en;
`ifdef LMC_CTRL_DRAIN_TIMEOUT_EN
    logic        drain_timeout;
`endif

    modport master (
        output cfg_req, cfg_gen, cfg_lanes, descramblerDataValid,
        input  cfg_ack, cfg_err, busy, lmc_gen, lmc_lanes, lmc_flush, lmc_valid_en
`ifdef LMC_CTRL_DRAIN_TIMEOUT_EN
        , drain_timeout
`endif
    );

    modport slave (
        input  cfg_req, cfg_gen, cfg_lanes, descramblerDataValid,
        output cfg_ack, cfg_err, busy, lmc_gen, lmc_lanes, lmc_flush, lmc_valid_en
`ifdef LMC_CTRL_DRAIN_TIMEOUT_EN
        , drain_timeout
`endif
    );
endinterface

// File: rtl/lmc_link_config_ctrl.sv
// Sequences GEN/LANESNUMBER changes into the RX LMC datapath: drain, flush, apply, settle.
// Optional drain timeout enabled by defining LMC_CTRL_DRAIN_TIMEOUT_EN.
module lmc_link_config_ctrl #(
    parameter int DRAIN_CYCLES   = 4,
    parameter int FLUSH_CYCLES   = 2,
    parameter int SETTLE_CYCLES  = 8
`ifdef LMC_CTRL_DRAIN_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    lmc_link_config_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_FLUSH, S_APPLY, S_SETTLE} state_t;

    localparam int CNT_MAX_A = (DRAIN_CYCLES > FLUSH_CYCLES) ? DRAIN_CYCLES : FLUSH_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > SETTLE_CYCLES) ? CNT_MAX_A : SETTLE_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t            r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next, w_cnt_inc;
    logic [2:0]        r_gen, r_gen_cap;
    logic [4:0]        r_lanes, r_lanes_cap;
    logic              r_ack, r_err, r_busy, r_flush, r_valid_en;
    logic              w_capture, w_apply, w_ack_next, w_err_next;
    logic              w_legal, w_same;

`ifdef LMC_CTRL_DRAIN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0]   r_to_cnt, w_to_cnt_next, w_to_inc;
    logic              r_drain_timeout, w_to_hit;

    assign w_to_inc = (r_to_cnt == {TO_W{1'b1}}) ? r_to_cnt : r_to_cnt + 1'b1;
`endif

    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_legal = (bus.cfg_gen >= 3'd1) && (bus.cfg_gen <= 3'd5);
        case (bus.cfg_lanes)
            5'd1, 5'd2, 5'd4, 5'd8, 5'd16: ;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_same = (bus.cfg_gen == r_gen) && (bus.cfg_lanes == r_lanes);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        w_apply      = 1'b0;
        w_ack_next   = 1'b0;
        w_err_next   = 1'b0;
`ifdef LMC_CTRL_DRAIN_TIMEOUT_EN
        w_to_cnt_next = '0;
        w_to_hit      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.cfg_req) begin
                    if (!w_legal) begin
                        w_err_next = 1'b1;
                    end else if (w_same) begin
                        w_ack_next = 1'b1;
                    end else begin
                        w_capture    = 1'b1;
                        w_cnt_next   = '0;
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Any lane still carrying data restarts the idle run.
                if (bus.descramblerDataValid != 16'd0) begin
                    w_cnt_next = '0;
                end else if (r_cnt == DRAIN_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = S_FLUSH;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
`ifdef LMC_CTRL_DRAIN_TIMEOUT_EN
                if (r_to_cnt == TO_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = S_FLUSH;
                    w_to_hit     = 1'b1;
                end else begin
                    w_to_cnt_next = w_to_inc;
                end
`endif
            end
            S_FLUSH: begin
                if (r_cnt == FLUSH_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = S_APPLY;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            S_APPLY: begin
                w_apply      = 1'b1;
                w_cnt_next   = '0;
                w_state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_cnt_next   = '0;
                    w_ack_next   = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_gen       <= 3'd1;
            r_lanes     <= 5'd1;
            r_gen_cap   <= 3'd1;
            r_lanes_cap <= 5'd1;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_flush     <= 1'b0;
            r_valid_en  <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_ack      <= w_ack_next;
            r_err      <= w_err_next;
            r_busy     <= (w_state_next != S_IDLE);
            r_flush    <= (w_state_next == S_FLUSH);
            r_valid_en <= (w_state_next == S_IDLE) || (w_state_next == S_DRAIN);
            if (w_capture) begin
                r_gen_cap   <= bus.cfg_gen;
                r_lanes_cap <= bus.cfg_lanes;
            end
            if (w_apply) begin
                r_gen   <= r_gen_cap;
                r_lanes <= r_lanes_cap;
            end
        end
    end

`ifdef LMC_CTRL_DRAIN_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt        <= '0;
            r_drain_timeout <= 1'b0;
        end else begin
            r_to_cnt <= w_to_cnt_next;
            if (w_to_hit) begin
                r_drain_timeout <= 1'b1;
            end
        end
    end

    assign bus.drain_timeout = r_drain_timeout;
`endif

    assign bus.cfg_ack      = r_ack;
    assign bus.cfg_err      = r_err;
    assign bus.busy         = r_busy;
    assign bus.lmc_gen      = r_gen;
    assign bus.lmc_lanes    = r_lanes;
    assign bus.lmc_flush    = r_flush;
    assign bus.lmc_valid_en = r_valid_en;
endmodule

// File: doc/lmc_link_config_ctrl.md
Name: lmc_link_config_ctrl

Overview:
- Sequences rate (GEN) and link-width (LANESNUMBER) changes into the RX Lane Management Control datapath.
- Sits between the LTSSM and the LMC/unstriping datapath.
- Accepts a config request, waits for descrambler traffic to drain, flushes the unstriping pipeline, applies the new config, then holds output valid low for a settle window.
- Guarantees GEN/LANESNUMBER never change while striped data is in flight.

Parameters:
DRAIN_CYCLES, 4, consecutive all-idle descrambler cycles required before flush (min 1)
FLUSH_CYCLES, 2, cycles lmc_flush is held high (min 1)
SETTLE_CYCLES, 8, cycles lmc_valid_en is held low after apply (min 1)
TIMEOUT_CYCLES, 64, drain timeout limit (used only with optional feature)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
cfg_req  input  1  request pulse/level from LTSSM; sampled only in IDLE
cfg_gen  input  3  requested generation, legal 1..5
cfg_lanes  input  5  requested lane count, legal 1,2,4,8,16
cfg_ack  output  1  one-cycle pulse: request completed
cfg_err  output  1  one-cycle pulse: request rejected (illegal fields)
busy  output  1  high whenever FSM not in IDLE
descramblerDataValid  input  16  per-lane valid from descramblers
lmc_gen  output  3  GEN driven to LMC datapath
lmc_lanes  output  5  LANESNUMBER driven to LMC datapath
lmc_flush  output  1  clears unstriping pipeline registers
lmc_valid_en  output  1  gate ANDed with LMC output valid
drain_timeout  output  1  sticky timeout flag (present only with LMC_CTRL_DRAIN_TIMEOUT_EN)

Behaviour:
- Reset values: lmc_gen=1, lmc_lanes=1, lmc_valid_en=1, lmc_flush=0, cfg_ack=0, cfg_err=0, busy=0, state=IDLE, counters=0, drain_timeout=0.
- Reset mid-operation: immediate return to reset values; in-flight request discarded, no ack.
- All outputs are registered.
- FSM states: IDLE, DRAIN, FLUSH, APPLY, SETTLE.
- IDLE, cfg_req=1, fields legal and different from current config: capture fields, go to DRAIN.
- IDLE, cfg_req=1, illegal fields (gen 0/6/7, lanes not a power of two ≤16): cfg_err pulses next cycle, stay IDLE, config unchanged.
- IDLE, cfg_req=1, fields equal to current config: cfg_ack pulses next cycle, no sequencing.
- DRAIN:
  - Counter increments when descramblerDataValid==0.
  - Counter clears to 0 on any nonzero descramblerDataValid.
  - Go to FLUSH in the cycle the counter reaches DRAIN_CYCLES-1 with idle input, so a fully idle drain takes exactly DRAIN_CYCLES cycles.
- FLUSH: lmc_flush=1 for exactly FLUSH_CYCLES cycles, then APPLY.
- APPLY: 1 cycle. lmc_gen/lmc_lanes load the captured values at the end of this cycle and are visible from the first SETTLE cycle.
- SETTLE: SETTLE_CYCLES cycles, then IDLE. cfg_ack=1 in the first IDLE cycle only.
- lmc_valid_en=1 in IDLE and DRAIN, 0 in FLUSH, APPLY, SETTLE.
- busy=1 in DRAIN, FLUSH, APPLY, SETTLE.
- cfg_req asserted outside IDLE is ignored, not queued. A request held high into IDLE after ack is treated as a new request.
- Counters saturate at the parameter width, with no wrap-around.
- Idle-path latency (request edge to ack) = DRAIN_CYCLES+FLUSH_CYCLES+1+SETTLE_CYCLES+1 cycles (16 at defaults).

Optional Feature:
- Macro: LMC_CTRL_DRAIN_TIMEOUT_EN.
- Defined:
  - A second counter counts every DRAIN cycle.
  - On reaching TIMEOUT_CYCLES, go to FLUSH regardless of traffic and set drain_timeout.
  - drain_timeout stays set until reset.
  - Sequencing otherwise unchanged.
- Undefined: port drain_timeout absent; DRAIN waits indefinitely for idle traffic.

Test Plan:
- Reset release, no request → lmc_gen=1, lmc_lanes=1, lmc_valid_en=1, busy=0 stable for 20 cycles.
- cfg_req with gen=3, lanes=8, descramblerDataValid=0 → busy 15 cycles; lmc_flush high cycles 5–6; lmc_gen=3/lmc_lanes=8 from cycle 8; lmc_valid_en low cycles 5–15; cfg_ack at cycle 16.
- Same request with descramblerDataValid=16'h00FF for 10 cycles after request, then 0 → FLUSH starts exactly 4 idle cycles after traffic stops; config unchanged during traffic.
- cfg_req with lanes=6, then gen=7 → cfg_err one-cycle pulse each; config stays 1/1; busy never asserts.
- Request equal to current config (1/1) → cfg_ack next cycle, lmc_flush never asserts. Reset asserted during SETTLE → outputs return to 1/1, no ack.
- With LMC_CTRL_DRAIN_TIMEOUT_EN, descramblerDataValid=16'h0001 held forever → FLUSH entered after 64 DRAIN cycles; drain_timeout=1 until reset; ack delivered.
